// File: rtl/register_file.sv
// Register file with one synchronous write port, two combinational read ports and a
// one-register-per-cycle clear sequencer. Optional write-to-read bypass: REGISTER_FILE_BYPASS_EN.

module register_file_mux #(
    parameter int P_NUM_REGS   = 16,
    parameter int P_DATA_WIDTH = 16
) (
    input  logic [P_NUM_REGS-1:0][P_DATA_WIDTH-1:0] i_data,
    input  logic [$clog2(P_NUM_REGS)-1:0]           i_sel,
    output logic [P_DATA_WIDTH-1:0]                 o_data
);
    assign o_data = i_data[i_sel];
endmodule

// state       | meaning
// ST_IDLE     | accepting writes, waiting for a clear request
// ST_CLEARING | zeroing register[clr_cnt] on every edge, writes dropped
module register_file #(
    parameter int P_NUM_REGS   = 16,
    parameter int P_DATA_WIDTH = 16
) (
    input  logic                          I_CLK,
    input  logic                          I_NRESET,
    input  logic                          I_WRITE_EN,
    input  logic [$clog2(P_NUM_REGS)-1:0] I_WRITE_ADDR,
    input  logic [P_DATA_WIDTH-1:0]       I_WRITE_DATA,
    input  logic [$clog2(P_NUM_REGS)-1:0] I_READ_ADDR_A,
    input  logic [$clog2(P_NUM_REGS)-1:0] I_READ_ADDR_B,
    output logic [P_DATA_WIDTH-1:0]       O_READ_DATA_A,
    output logic [P_DATA_WIDTH-1:0]       O_READ_DATA_B,
    input  logic                          I_CLEAR,
    output logic                          O_BUSY
);
    localparam int AW = $clog2(P_NUM_REGS);

    typedef enum logic {
        ST_IDLE,
        ST_CLEARING
    } state_t;

    state_t                                  state_q, state_d;
    logic [AW-1:0]                           clr_cnt_q, clr_cnt_d;
    logic [P_NUM_REGS-1:0][P_DATA_WIDTH-1:0] regs_q, regs_d;
    logic                                    busy_q, busy_d;
    logic                                    write_accept;
    logic [P_DATA_WIDTH-1:0]                 mux_a, mux_b;

    // A write only lands when idle and not overridden by a same-cycle clear request.
    assign write_accept = (state_q == ST_IDLE) && I_WRITE_EN && !I_CLEAR;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        regs_d    = regs_q;
        case (state_q)
            ST_IDLE: begin
                if (I_CLEAR) begin
                    state_d   = ST_CLEARING;
                    clr_cnt_d = '0;
                end else if (I_WRITE_EN) begin
                    regs_d[I_WRITE_ADDR] = I_WRITE_DATA;
                end
            end
            ST_CLEARING: begin
                regs_d[clr_cnt_q] = '0;
                clr_cnt_d         = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(P_NUM_REGS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CLEARING);
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            regs_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            regs_q    <= regs_d;
            busy_q    <= busy_d;
        end
    end

    assign O_BUSY = busy_q;

    register_file_mux #(
        .P_NUM_REGS   (P_NUM_REGS),
        .P_DATA_WIDTH (P_DATA_WIDTH)
    ) u_mux_a (
        .i_data (regs_q),
        .i_sel  (I_READ_ADDR_A),
        .o_data (mux_a)
    );

    register_file_mux #(
        .P_NUM_REGS   (P_NUM_REGS),
        .P_DATA_WIDTH (P_DATA_WIDTH)
    ) u_mux_b (
        .i_data (regs_q),
        .i_sel  (I_READ_ADDR_B),
        .o_data (mux_b)
    );

`ifdef REGISTER_FILE_BYPASS_EN
    assign O_READ_DATA_A = (write_accept && (I_WRITE_ADDR == I_READ_ADDR_A)) ? I_WRITE_DATA : mux_a;
    assign O_READ_DATA_B = (write_accept && (I_WRITE_ADDR == I_READ_ADDR_B)) ? I_WRITE_DATA : mux_b;
`else
    // write_accept only matters for the bypass; without it reads see flop contents.
    logic unused_write_accept;
    assign unused_write_accept = write_accept;
    assign O_READ_DATA_A = mux_a;
    assign O_READ_DATA_B = mux_b;
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (16 x 16); expectations adapt to
// REGISTER_FILE_BYPASS_EN when the bench is compiled with it.

module tb_register_file;
    logic        I_CLK;
    logic        I_NRESET;
    logic        I_WRITE_EN;
    logic [3:0]  I_WRITE_ADDR;
    logic [15:0] I_WRITE_DATA;
    logic [3:0]  I_READ_ADDR_A;
    logic [3:0]  I_READ_ADDR_B;
    logic [15:0] O_READ_DATA_A;
    logic [15:0] O_READ_DATA_B;
    logic        I_CLEAR;
    logic        O_BUSY;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt;

    register_file #(
        .P_NUM_REGS   (16),
        .P_DATA_WIDTH (16)
    ) dut (
        .I_CLK         (I_CLK),
        .I_NRESET      (I_NRESET),
        .I_WRITE_EN    (I_WRITE_EN),
        .I_WRITE_ADDR  (I_WRITE_ADDR),
        .I_WRITE_DATA  (I_WRITE_DATA),
        .I_READ_ADDR_A (I_READ_ADDR_A),
        .I_READ_ADDR_B (I_READ_ADDR_B),
        .O_READ_DATA_A (O_READ_DATA_A),
        .O_READ_DATA_B (O_READ_DATA_B),
        .I_CLEAR       (I_CLEAR),
        .O_BUSY        (O_BUSY)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        I_WRITE_EN   = 1'b1;
        I_WRITE_ADDR = a;
        I_WRITE_DATA = d;
        tick();
        I_WRITE_EN   = 1'b0;
    endtask

    initial begin
        I_NRESET = 1'b0; I_WRITE_EN = 1'b0; I_WRITE_ADDR = '0; I_WRITE_DATA = '0;
        I_READ_ADDR_A = '0; I_READ_ADDR_B = '0; I_CLEAR = 1'b0;
        repeat (2) tick();
        chk("reset_busy", 32'(O_BUSY), 32'd0);
        I_NRESET = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            I_READ_ADDR_A = 4'(i);
            I_READ_ADDR_B = 4'(15 - i);
            #1;
            chk($sformatf("reset_rd_a%0d", i), 32'(O_READ_DATA_A), 32'h0);
            chk($sformatf("reset_rd_b%0d", 15 - i), 32'(O_READ_DATA_B), 32'h0);
        end
        chk("idle_busy", 32'(O_BUSY), 32'd0);

        // basic writes on consecutive cycles
        I_WRITE_EN = 1'b1; I_WRITE_ADDR = 4'd3; I_WRITE_DATA = 16'hA5A5;
        tick();
        I_WRITE_ADDR = 4'd15; I_WRITE_DATA = 16'h1234;
        tick();
        I_WRITE_EN = 1'b0;
        I_READ_ADDR_A = 4'd3; I_READ_ADDR_B = 4'd15;
        #1;
        chk("wr_r3", 32'(O_READ_DATA_A), 32'hA5A5);
        chk("wr_r15", 32'(O_READ_DATA_B), 32'h1234);

        // same-cycle read of the register being written
        I_READ_ADDR_A = 4'd7; I_READ_ADDR_B = 4'd7;
        I_WRITE_EN = 1'b1; I_WRITE_ADDR = 4'd7; I_WRITE_DATA = 16'hBEEF;
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        chk("bypass_a", 32'(O_READ_DATA_A), 32'hBEEF);
        chk("bypass_b", 32'(O_READ_DATA_B), 32'hBEEF);
`else
        chk("nobypass_a", 32'(O_READ_DATA_A), 32'h0);
        chk("nobypass_b", 32'(O_READ_DATA_B), 32'h0);
`endif
        tick();
        I_WRITE_EN = 1'b0;
        #1;
        chk("post_wr_a", 32'(O_READ_DATA_A), 32'hBEEF);
        chk("post_wr_b", 32'(O_READ_DATA_B), 32'hBEEF);

        // fill, then clear with a mid-clear write and a mid-clear clear request
        for (int i = 0; i < 16; i++) wr(4'(i), 16'h1001 + 16'(i));
        I_CLEAR = 1'b1;
        tick();
        I_CLEAR = 1'b0;
        chk("clr_busy_rise", 32'(O_BUSY), 32'd1);
        busy_cnt = 0;
        while (O_BUSY && busy_cnt < 40) begin
            busy_cnt++;
            if (busy_cnt == 3) begin
                I_WRITE_EN = 1'b1; I_WRITE_ADDR = 4'd9; I_WRITE_DATA = 16'h7777;
                I_READ_ADDR_A = 4'd9;
                #1;
                chk("clr_no_bypass_r9", 32'(O_READ_DATA_A), 32'h100A);
            end
            if (busy_cnt == 4) begin
                I_WRITE_EN = 1'b0; I_CLEAR = 1'b1;
            end
            if (busy_cnt == 5) I_CLEAR = 1'b0;
            tick();
            if (busy_cnt == 5) begin
                for (int i = 0; i < 5; i++) begin
                    I_READ_ADDR_A = 4'(i);
                    #1;
                    chk($sformatf("partial_clr_r%0d", i), 32'(O_READ_DATA_A), 32'h0);
                end
                I_READ_ADDR_B = 4'd5;
                #1;
                chk("partial_old_r5", 32'(O_READ_DATA_B), 32'h1006);
            end
        end
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd16);
        for (int i = 0; i < 16; i++) begin
            I_READ_ADDR_A = 4'(i);
            #1;
            chk($sformatf("after_clr_r%0d", i), 32'(O_READ_DATA_A), 32'h0);
        end

        // clear and write in the same cycle: write dropped, no bypass
        wr(4'd2, 16'h5555);
        I_READ_ADDR_A = 4'd2;
        I_CLEAR = 1'b1; I_WRITE_EN = 1'b1; I_WRITE_ADDR = 4'd2; I_WRITE_DATA = 16'h00FF;
        #1;
        chk("clr_wr_no_bypass", 32'(O_READ_DATA_A), 32'h5555);
        tick();
        I_CLEAR = 1'b0; I_WRITE_EN = 1'b0;
        busy_cnt = 0;
        while (O_BUSY && busy_cnt < 40) begin
            busy_cnt++;
            tick();
        end
        chk("clr_wr_busy_cycles", 32'(busy_cnt), 32'd16);
        #1;
        chk("clr_wr_r2", 32'(O_READ_DATA_A), 32'h0);

        // reset in the middle of a clear
        wr(4'd10, 16'hCAFE);
        wr(4'd1, 16'h0B0B);
        I_CLEAR = 1'b1;
        tick();
        I_CLEAR = 1'b0;
        repeat (6) tick();
        chk("mid_clr_busy", 32'(O_BUSY), 32'd1);
        #2;
        I_NRESET = 1'b0;
        #1;
        chk("rst_busy_immediate", 32'(O_BUSY), 32'd0);
        for (int i = 0; i < 16; i++) begin
            I_READ_ADDR_A = 4'(i);
            #0.1;
            chk($sformatf("rst_mid_r%0d", i), 32'(O_READ_DATA_A), 32'h0);
        end
        tick();
        I_NRESET = 1'b1;
        tick();
        chk("no_resume_busy", 32'(O_BUSY), 32'd0);
        wr(4'd1, 16'h4321);
        I_READ_ADDR_A = 4'd1; I_READ_ADDR_B = 4'd10;
        #1;
        chk("post_rst_wr_r1", 32'(O_READ_DATA_A), 32'h4321);
        chk("post_rst_r10", 32'(O_READ_DATA_B), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/register_file.md
# register_file

Register file with parameterized depth and width: one synchronous write port and two read ports. Each read port is a parameterized `P_NUM_REGS`-to-1 mux instance driven by a read address. It sits directly upstream of the datapath operand muxes and the ALU, and supplies operands A and B every cycle. A small sequencer clears the entire array on request, one register per cycle, without using the global reset.

## Interface
- `P_NUM_REGS`, default 16: number of registers. Must be a power of two and ≥ 2.
- `P_DATA_WIDTH`, default 16: bits per register.

- `I_CLK`  input  1  system clock; all state updates on its rising edge.
- `I_NRESET`  input  1  reset. Asynchronous, active-low.
- `I_WRITE_EN`  input  1  write strobe, sampled on the rising edge.
- `I_WRITE_ADDR`  input  `$clog2(P_NUM_REGS)`  write register index.
- `I_WRITE_DATA`  input  `P_DATA_WIDTH`  write value.
- `I_READ_ADDR_A`  input  `$clog2(P_NUM_REGS)`  read index, port A.
- `I_READ_ADDR_B`  input  `$clog2(P_NUM_REGS)`  read index, port B.
- `O_READ_DATA_A`  output  `P_DATA_WIDTH`  contents of register `I_READ_ADDR_A`.
- `O_READ_DATA_B`  output  `P_DATA_WIDTH`  contents of register `I_READ_ADDR_B`.
- `I_CLEAR`  input  1  single-cycle request to zero all registers.
- `O_BUSY`  output  1  high while the clear sequence is running.

## Operation
**Storage**
- `P_NUM_REGS` × `P_DATA_WIDTH` flops.
- `I_NRESET` low forces, immediately and regardless of the clock:
  - every register to 0;
  - the sequencer to IDLE;
  - the clear counter to 0;
  - `O_BUSY` to 0.

**Reads**
- Purely combinational through the mux instances.
- Both ports are fully independent; they may address the same register.

**Writes**
- When the sequencer is IDLE, `I_WRITE_EN`=1 and `I_CLEAR`=0: register `I_WRITE_ADDR` ← `I_WRITE_DATA` at the edge.

**Clear sequencer** (two states)
- IDLE:
  - `I_CLEAR`=1 at an edge → go to CLEARING, counter ← 0.
  - Any write in that same cycle is dropped.
- CLEARING:
  - Each edge writes 0 to register[counter] and increments the counter.
  - After writing register `P_NUM_REGS`-1: return to IDLE, counter wraps to 0.
- `O_BUSY` = (state == CLEARING). It is a registered output.

**Boundary rules**
- `I_WRITE_EN` during CLEARING: ignored; the write is lost, not queued.
- `I_CLEAR` during CLEARING: ignored; the sequence does not restart.
- Reads during CLEARING return current contents. Registers not yet cleared still hold old values.
- `I_NRESET` asserted mid-clear: full reset takes effect; nothing resumes after reset is released.

## Timing
- Read latency: combinational. The output changes in the same cycle as the address.
- Write latency: the new value is visible on the read ports after the writing edge.
  - Exception: the write-bypass path; see Configuration.
- Clear occupancy: `O_BUSY` rises at the edge that samples `I_CLEAR`. It stays high exactly `P_NUM_REGS` cycles and falls at the edge that clears the last register.
- The first accepted write after a clear is in the cycle where `O_BUSY` is 0.
- Reset value of each output:
  - `O_BUSY` = 0;
  - `O_READ_DATA_A` and `O_READ_DATA_B` = 0, since all registers are 0.

## Configuration
- Macro: `REGISTER_FILE_BYPASS_EN`.
- When defined, a read port outputs `I_WRITE_DATA` in the same cycle if both of these hold:
  - a write will be accepted this cycle (IDLE, `I_WRITE_EN`=1, `I_CLEAR`=0);
  - `I_WRITE_ADDR` equals that port's read address.
- The bypass never applies during CLEARING, nor to a write that a simultaneous `I_CLEAR` drops.
- When undefined: no bypass. A port shows the old value until after the edge.

## Test plan
- Reset, then drive every read address on both ports → both ports read 0 for all 16 registers; `O_BUSY`=0.
- Write 0xA5A5 to r3 and 0x1234 to r15 on consecutive cycles. Then read A=r3, B=r15 → 0xA5A5 and 0x1234.
- Write 0xBEEF to r7 while A=r7 and B=r7:
  - with the macro defined, both ports read 0xBEEF in that cycle;
  - without it, both read the old value, then 0xBEEF after the edge.
- Fill all registers with nonzero values, pulse `I_CLEAR`:
  - `O_BUSY` stays high exactly 16 cycles;
  - after 5 cycles r0–r4 read 0 and r5 still reads its old value;
  - a write to r9 issued mid-clear is lost, and r9 reads 0 at the end.
- Assert `I_CLEAR` and `I_WRITE_EN` (r2, 0x00FF) together → the write is dropped, r2 ends at 0, `O_BUSY` is high for 16 cycles.
- Assert `I_NRESET` low mid-clear (counter=6), then release → `O_BUSY`=0 immediately and all registers read 0. A write to r1 on the next cycle succeeds.
